uart_tx_arbiter: RTL

//  Shares the single 8N1 UART byte transmitter between NUM_REQ message sources (stats dump, RX echo, alarm text).

---
 rtl/uart_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and line timing constants.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam int CLK_HZ = 27_000_000;
   localparam int BAUD   = 115_200;
   // One bit time at 115200 baud from a 27 MHz clock, truncated to whole cycles (234).
   localparam int DELAY_FRAMES = CLK_HZ / BAUD;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the first requesting index after last_grant, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [1:0]         last_grant,
   output logic [1:0]         grant,
   output logic               any
);

   logic [1:0] lo_idx;
   logic [1:0] hi_idx;
   logic       lo_hit;
   logic       hi_hit;

   // Lowest requester above last_grant wins; otherwise wrap to the lowest requester overall.
   always_comb begin
      lo_idx = 2'd0;
      hi_idx = 2'd0;
      lo_hit = 1'b0;
      hi_hit = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_hit = 1'b1;
            lo_idx = 2'(i);
            if (2'(i) > last_grant) begin
               hi_hit = 1'b1;
               hi_idx = 2'(i);
            end
         end
      end
      any   = lo_hit;
      grant = hi_hit ? hi_idx : lo_idx;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte serialiser between several message sources, one whole message per grant,
// round-robin, with a forced idle gap on the line after every message.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ       = 3,
   parameter int GAP_CYCLES    = DELAY_FRAMES,
   parameter int MAX_MSG_BYTES = 96
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic [1:0]           grant_id,
   output logic                 busy,
   output logic                 truncated
);

   localparam int BW = $clog2(MAX_MSG_BYTES + 1);
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
   localparam logic [BW-1:0] CNT_LAST = BW'(MAX_MSG_BYTES - 1);

   state_t          state;
   logic [1:0]      last_grant;
   logic [BW-1:0]   byte_cnt;
   logic [GW-1:0]   gap_cnt;
   logic [1:0]      pick;
   logic            pick_any;
   logic            sel_valid;
   logic            sel_last;
   logic [7:0]      sel_data;
   logic            granting;
   logic            xfer;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .req        (req_valid),
      .last_grant (last_grant),
      .grant      (pick),
      .any        (pick_any)
   );

   // Pass-through of the owner's stream; nothing is registered on the data path.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = 8'h00;
      req_ready = '0;
      granting  = (state == ST_GRANT);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == 2'(i)) begin
            sel_valid    = req_valid[i];
            sel_last     = req_last[i];
            sel_data     = req_data[8*i +: 8];
            req_ready[i] = granting & tx_ready;
         end
      end
      tx_valid = granting & sel_valid;
      tx_data  = granting ? sel_data : 8'h00;
      xfer     = tx_valid & tx_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         grant_id   <= 2'd0;
         last_grant <= 2'(NUM_REQ - 1);
         byte_cnt   <= '0;
         gap_cnt    <= '0;
         busy       <= 1'b0;
         truncated  <= 1'b0;
      end else begin
         truncated <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  grant_id   <= pick;
                  last_grant <= pick;
                  byte_cnt   <= '0;
                  busy       <= 1'b1;
                  state      <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               // A last byte landing exactly on the watchdog limit is a normal end, not a truncation.
               if (xfer) begin
                  byte_cnt <= byte_cnt + 1'b1;
                  if (sel_last) begin
                     gap_cnt <= '0;
                     state   <= ST_GAP;
                  end else if (byte_cnt == CNT_LAST) begin
                     truncated <= 1'b1;
                     gap_cnt   <= '0;
                     state     <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  gap_cnt <= '0;
                  busy    <= 1'b0;
                  state   <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
